// File: rtl/sram_port_arbiter.sv
// Shares one synchronous SRAM port between a fetch and a load/store requester, one access per cycle.
// Optional ARB_ROUND_ROBIN_EN: alternate winners on conflict; otherwise data always wins.
module sram_port_arbiter (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic [3:0]  data_wen,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        sram_en,
  output logic [3:0]  sram_wen,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_wdata,
  input  logic [31:0] sram_rdata
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RESP_I = 2'd1;
  localparam logic [1:0] RESP_D = 2'd2;

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       grant_i;
  logic       grant_d;
  logic       data_wins;

`ifdef ARB_ROUND_ROBIN_EN
  localparam logic GRANT_FETCH = 1'b0;
  localparam logic GRANT_DATA  = 1'b1;

  logic last_grant;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      last_grant <= GRANT_FETCH;
    end else if (grant_d) begin
      last_grant <= GRANT_DATA;
    end else if (grant_i) begin
      last_grant <= GRANT_FETCH;
    end
  end

  // On conflict the side that did not win last time goes first.
  assign data_wins = (last_grant == GRANT_FETCH);
`else
  assign data_wins = 1'b1;
`endif

  always_comb begin
    grant_d = resetn && data_req && (!inst_req || data_wins);
    grant_i = resetn && inst_req && !grant_d;
  end

  always_comb begin
    state_nxt = IDLE;
    if (grant_i) begin
      state_nxt = RESP_I;
    end else if (grant_d) begin
      state_nxt = RESP_D;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  assign inst_addr_ok = grant_i;
  assign data_addr_ok = grant_d;

  assign sram_en    = grant_i || grant_d;
  assign sram_wen   = grant_d ? data_wen : 4'b0000;
  assign sram_addr  = grant_d ? data_addr : inst_addr;
  assign sram_wdata = data_wdata;

  // The response owner is known purely from which grant happened last cycle.
  assign inst_data_ok = (state == RESP_I);
  assign data_data_ok = (state == RESP_D);
  assign inst_rdata   = sram_rdata;
  assign data_rdata   = sram_rdata;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Randomized scoreboard bench for sram_port_arbiter with a behavioural SRAM and reference model.
module tb_sram_port_arbiter;

  logic        clk;
  logic        resetn;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req;
  logic [3:0]  data_wen;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic        sram_en;
  logic [3:0]  sram_wen;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;

  sram_port_arbiter dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wen(data_wen), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .sram_en(sram_en), .sram_wen(sram_wen), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata)
  );

  typedef struct {
    int          c;
    bit          kind_d;
    bit          is_rd;
    logic [31:0] d;
  } resp_t;

  resp_t       q[$];
  int          cyc = 0;
  int          n_vec = 0;
  int          n_miss = 0;
  logic [31:0] sram_mem[logic [29:0]];
  logic [31:0] ref_mem[logic [29:0]];
  bit          m_last_data = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [31:0] dflt(input logic [29:0] w);
    return {w, 2'b00} ^ 32'h5a5a_c3c3;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  // Behavioural SRAM: one-cycle synchronous read, byte-enabled write.
  always @(posedge clk) begin
    if (sram_en) begin
      if (!sram_mem.exists(sram_addr[31:2])) sram_mem[sram_addr[31:2]] = dflt(sram_addr[31:2]);
      sram_rdata <= sram_mem[sram_addr[31:2]];
      if (sram_wen != 4'b0000)
        sram_mem[sram_addr[31:2]] = merge(sram_mem[sram_addr[31:2]], sram_wdata, sram_wen);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    if (!ref_mem.exists(a[31:2])) ref_mem[a[31:2]] = dflt(a[31:2]);
    return ref_mem[a[31:2]];
  endfunction

  // Scoreboard monitor: every response the model scheduled must appear exactly in its cycle.
  always @(negedge clk) begin
    bit exp_i;
    bit exp_d;
    if (!resetn) begin
      while (q.size() > 0 && q[0].c <= cyc) void'(q.pop_front());
    end else begin
      while (q.size() > 0 && q[0].c < cyc) begin
        chk("lost_response", 32'd0, 32'd1);
        void'(q.pop_front());
      end
      exp_i = (q.size() > 0) && (q[0].c == cyc) && !q[0].kind_d;
      exp_d = (q.size() > 0) && (q[0].c == cyc) && q[0].kind_d;
      chk("inst_data_ok", {31'd0, inst_data_ok}, {31'd0, exp_i});
      chk("data_data_ok", {31'd0, data_data_ok}, {31'd0, exp_d});
      if (exp_i) chk("inst_rdata", inst_rdata, q[0].d);
      if (exp_d && q[0].is_rd) chk("data_rdata", data_rdata, q[0].d);
      if (exp_i || exp_d) void'(q.pop_front());
    end
  end

  // One cycle of stimulus; the reference model decides the grant and schedules the response.
  task automatic step(input logic rn, input logic ir, input logic [31:0] ia,
                      input logic dr, input logic [3:0] dw, input logic [31:0] da,
                      input logic [31:0] dd, output logic gi, output logic gd);
    bit    data_first;
    resp_t r;
    @(posedge clk);
    #2;
    resetn = rn; inst_req = ir; inst_addr = ia;
    data_req = dr; data_wen = dw; data_addr = da; data_wdata = dd;
    #1;
`ifdef ARB_ROUND_ROBIN_EN
    data_first = !m_last_data;
`else
    data_first = 1'b1;
`endif
    gd = rn && dr && (!ir || data_first);
    gi = rn && ir && !gd;
    chk("inst_addr_ok", {31'd0, inst_addr_ok}, {31'd0, gi});
    chk("data_addr_ok", {31'd0, data_addr_ok}, {31'd0, gd});
    chk("sram_en", {31'd0, sram_en}, {31'd0, gi || gd});
    chk("sram_wen", {28'd0, sram_wen}, gd ? {28'd0, dw} : 32'd0);
    if (gi) chk("sram_addr_i", sram_addr, ia);
    if (gd) chk("sram_addr_d", sram_addr, da);
    if (gd && dw != 4'b0000) chk("sram_wdata", sram_wdata, dd);
    if (gi) begin
      r.c = cyc + 1; r.kind_d = 0; r.is_rd = 1; r.d = ref_read(ia);
      q.push_back(r);
    end
    if (gd) begin
      r.c = cyc + 1; r.kind_d = 1; r.is_rd = (dw == 4'b0000); r.d = ref_read(da);
      if (dw != 4'b0000) ref_mem[da[31:2]] = merge(r.d, dd, dw);
      q.push_back(r);
    end
    if (!rn) m_last_data = 0;
    else if (gd) m_last_data = 1;
    else if (gi) m_last_data = 0;
  endtask

  initial begin
    logic        gi, gd;
    logic        pi, pd;
    logic [31:0] pa, pda, pdd;
    logic [3:0]  pw;
    logic        rn;
    resetn = 1'b0; inst_req = 1'b0; inst_addr = '0; data_req = 1'b0;
    data_wen = '0; data_addr = '0; data_wdata = '0;

    // Reset, including requests held high while in reset.
    step(0, 0, 0, 0, 0, 0, 0, gi, gd);
    step(0, 1, 32'hbfc0_0000, 1, 4'hf, 32'h8000_0000, 32'h1, gi, gd);
    step(1, 0, 0, 0, 0, 0, 0, gi, gd);
    // Fetch only.
    step(1, 1, 32'hbfc0_0000, 0, 0, 0, 0, gi, gd);
    step(1, 0, 0, 0, 0, 0, 0, gi, gd);
    // Store then read back.
    step(1, 0, 0, 1, 4'hf, 32'h8000_0010, 32'h1234_5678, gi, gd);
    step(1, 0, 0, 1, 4'h0, 32'h8000_0010, 0, gi, gd);
    step(1, 0, 0, 0, 0, 0, 0, gi, gd);
    chk("store_readback", ref_mem[30'h2000_0004], 32'h1234_5678);
    // Conflict from reset state for four cycles.
    step(0, 0, 0, 0, 0, 0, 0, gi, gd);
    for (int k = 0; k < 4; k++)
      step(1, 1, 32'hbfc0_0004 + 32'(k*4), 1, 4'h0, 32'h8000_0020 + 32'(k*4), 0, gi, gd);
    step(1, 0, 0, 0, 0, 0, 0, gi, gd);
    // Back-to-back fetch then data.
    step(1, 1, 32'hbfc0_0008, 0, 0, 0, 0, gi, gd);
    step(1, 0, 0, 1, 4'h3, 32'h8000_0004, 32'hdead_beef, gi, gd);
    step(1, 0, 0, 0, 0, 0, 0, gi, gd);
    // Reset in the cycle after a grant.
    step(1, 1, 32'hbfc0_000c, 0, 0, 0, 0, gi, gd);
    step(0, 1, 32'hbfc0_000c, 1, 4'h0, 32'h8000_0000, 0, gi, gd);
    step(1, 0, 0, 0, 0, 0, 0, gi, gd);
    step(1, 0, 0, 0, 0, 0, 0, gi, gd);

    // Random traffic; an ungranted requester holds its request.
    pi = 0; pd = 0; pa = 0; pda = 0; pdd = 0; pw = 0;
    for (int n = 0; n < 1500; n++) begin
      rn = ($urandom_range(0, 149) != 0);
      if (!pi && $urandom_range(0, 2) != 0) begin
        pi = 1; pa = 32'h8000_0000 | (32'($urandom_range(0, 7)) << 2);
      end
      if (!pd && $urandom_range(0, 2) != 0) begin
        pd = 1; pda = 32'h8000_0000 | (32'($urandom_range(0, 7)) << 2);
        pw = $urandom_range(0, 1) ? 4'h0 : 4'($urandom_range(1, 15));
        pdd = $urandom;
      end
      step(rn, pi, pa, pd, pw, pda, pdd, gi, gd);
      if (gi || !rn) pi = 0;
      if (gd || !rn) pd = 0;
    end
    for (int k = 0; k < 4; k++) step(1, 0, 0, 0, 0, 0, 0, gi, gd);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
